// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, frame length, common host commands
// and the odd-parity helper used when a byte is latched.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        SEND      = 3'd2,
        ACK       = 3'd3,
        WAIT_IDLE = 3'd4
    } ps2_state_e;

    localparam int unsigned PS2_FRAME_EDGES = 11;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines plus a falling-edge
// detector on the synchronized clock; shared by the host transmitter and receiver.
module ps2_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clk_raw,
    input  logic i_data_raw,
    output logic o_clk_sync,
    output logic o_data_sync,
    output logic o_clk_fall
);

    logic r_clk_meta;
    logic r_clk_sync;
    logic r_clk_prev;
    logic r_data_meta;
    logic r_data_sync;

    // Synchronizer chains; idle lines are high so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= i_clk_raw;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= i_data_raw;
            r_data_sync <= r_data_meta;
        end
    end

    assign o_clk_sync  = r_clk_sync;
    assign o_data_sync = r_data_sync;
    assign o_clk_fall  = r_clk_prev & ~r_clk_sync;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-edge frame, ack, idle.
// Define PS2_TX_ACK_CHECK_EN to turn a missing device ack into an err pulse.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    output logic       done,
    output logic       err
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_ONE  = INH_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [3:0]       LAST_BIT_EDGE = 4'(PS2_FRAME_EDGES - 1);

    logic w_clk_s;
    logic w_data_s;
    logic w_clk_fall;

    ps2_state_e       r_state,    w_state_nxt;
    logic [INH_W-1:0] r_inh_cnt,  w_inh_cnt_nxt;
    logic [TO_W-1:0]  r_to_cnt,   w_to_cnt_nxt;
    logic [3:0]       r_edge_cnt, w_edge_cnt_nxt;
    logic [9:0]       r_shift,    w_shift_nxt;
    logic             r_clk_oe,   w_clk_oe_nxt;
    logic             r_data_oe,  w_data_oe_nxt;
    logic             r_done,     w_done_nxt;
    logic             r_err,      w_err_nxt;
    logic             r_tx_ready, w_tx_ready_nxt;
    logic [3:0]       w_edge_inc;
    logic             w_timeout;
`ifdef PS2_TX_ACK_CHECK_EN
    logic             r_ack,      w_ack_nxt;
`endif

    ps2_sync u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clk_raw   (ps2clk_in),
        .i_data_raw  (ps2data_in),
        .o_clk_sync  (w_clk_s),
        .o_data_sync (w_data_s),
        .o_clk_fall  (w_clk_fall)
    );

    assign w_edge_inc = r_edge_cnt + 4'd1;
    assign w_timeout  = ((r_state == SEND) || (r_state == ACK) || (r_state == WAIT_IDLE))
                        && (r_to_cnt == TO_LAST);

    // Next-state and next-output logic; outputs are registered so they track the state.
    always_comb begin
        w_state_nxt    = r_state;
        w_inh_cnt_nxt  = r_inh_cnt;
        w_to_cnt_nxt   = r_to_cnt;
        w_edge_cnt_nxt = r_edge_cnt;
        w_shift_nxt    = r_shift;
        w_clk_oe_nxt   = 1'b0;
        w_data_oe_nxt  = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
        w_ack_nxt      = r_ack;
`endif
        if (w_timeout) begin
            w_state_nxt = IDLE;
            w_err_nxt   = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (tx_valid && r_tx_ready) begin
                        w_shift_nxt    = {1'b1, odd_parity(tx_data), tx_data};
                        w_inh_cnt_nxt  = {INH_W{1'b0}};
                        w_edge_cnt_nxt = 4'd0;
                        w_clk_oe_nxt   = 1'b1;
                        w_data_oe_nxt  = (INH_LAST == {INH_W{1'b0}});
                        w_state_nxt    = INHIBIT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                INHIBIT: begin
                    if (r_inh_cnt == INH_LAST) begin
                        w_to_cnt_nxt  = {TO_W{1'b0}};
                        w_data_oe_nxt = 1'b1;
                        w_state_nxt   = SEND;
                    end else begin
                        w_inh_cnt_nxt = r_inh_cnt + INH_ONE;
                        w_clk_oe_nxt  = 1'b1;
                        w_data_oe_nxt = ((r_inh_cnt + INH_ONE) == INH_LAST);
                    end
                end
                SEND: begin
                    w_to_cnt_nxt  = r_to_cnt + TO_ONE;
                    w_data_oe_nxt = r_data_oe;
                    if (w_clk_fall) begin
                        // Shift order is data LSB first, then parity, then stop (1 = released).
                        w_edge_cnt_nxt = w_edge_inc;
                        w_data_oe_nxt  = ~r_shift[0];
                        w_shift_nxt    = {1'b0, r_shift[9:1]};
                        w_state_nxt    = (w_edge_inc == LAST_BIT_EDGE) ? ACK : SEND;
                    end else begin
                        w_state_nxt = SEND;
                    end
                end
                ACK: begin
                    w_to_cnt_nxt = r_to_cnt + TO_ONE;
                    if (w_clk_fall) begin
                        w_edge_cnt_nxt = w_edge_inc;
`ifdef PS2_TX_ACK_CHECK_EN
                        w_ack_nxt      = w_data_s;
`endif
                        w_state_nxt    = WAIT_IDLE;
                    end else begin
                        w_state_nxt = ACK;
                    end
                end
                WAIT_IDLE: begin
                    w_to_cnt_nxt = r_to_cnt + TO_ONE;
                    if (w_clk_s && w_data_s) begin
`ifdef PS2_TX_ACK_CHECK_EN
                        w_err_nxt  = r_ack;
                        w_done_nxt = ~r_ack;
`else
                        w_done_nxt = 1'b1;
`endif
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = WAIT_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
        w_tx_ready_nxt = (w_state_nxt == IDLE);
    end

    // State, datapath and registered outputs; reset releases both lines at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_inh_cnt  <= {INH_W{1'b0}};
            r_to_cnt   <= {TO_W{1'b0}};
            r_edge_cnt <= 4'd0;
            r_shift    <= 10'd0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_tx_ready <= 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
            r_ack      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_inh_cnt  <= w_inh_cnt_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_edge_cnt <= w_edge_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_clk_oe   <= w_clk_oe_nxt;
            r_data_oe  <= w_data_oe_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_tx_ready <= w_tx_ready_nxt;
`ifdef PS2_TX_ACK_CHECK_EN
            r_ack      <= w_ack_nxt;
`endif
        end
    end

    assign tx_ready   = r_tx_ready;
    assign ps2clk_oe  = r_clk_oe;
    assign ps2data_oe = r_data_oe;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed and randomized bench for ps2_tx with an open-drain line model and a
// behavioural PS/2 device that clocks frames, samples the data line and returns an ack.
module tb_ps2_tx;
    import ps2_pkg::*;

    localparam int INH = 20;
    localparam int TO  = 3000;
    localparam int H   = 8;
`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit ACK_CHK = 1'b1;
`else
    localparam bit ACK_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2clk_in, ps2data_in;
    logic       ps2clk_oe, ps2data_oe;
    logic       done, err;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    assign ps2clk_in  = dev_clk  & ~ps2clk_oe;
    assign ps2data_in = dev_data & ~ps2data_oe;

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2clk_in  (ps2clk_in),
        .ps2data_in (ps2data_in),
        .ps2clk_oe  (ps2clk_oe),
        .ps2data_oe (ps2data_oe),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (done === 1'b1 && err === 1'b1) both_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected data-line sequence: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_model(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i + 1] = b[i];
            ones += int'(b[i]);
        end
        f[9] = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] b, input bit hold);
        int n;
        int dcount;
        logic last;
        n = 0;
        while (tx_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk("ready_before_send", tx_ready, 1);
        tx_data = b;
        tx_valid = 1'b1;
        tick();
        if (hold) begin
            tx_data = 8'hAA;
        end else begin
            tx_valid = 1'b0;
            tx_data = 8'($urandom);
        end
        n = 0;
        dcount = 0;
        last = 1'b0;
        while (ps2clk_oe === 1'b1 && n < INH + 100) begin
            n++;
            dcount += int'(ps2data_oe);
            last = ps2data_oe;
            tick();
        end
        chk("inhibit_len", n, INH);
        chk("inhibit_data_cycles", dcount, 1);
        chk("inhibit_data_last", last, 1);
        chk("send_start_oe", ps2data_oe, 1);
        chk("busy_ready", tx_ready, 0);
    endtask

    task automatic device(input logic ack, input int nedges, output logic [10:0] bits);
        bits = '1;
        for (int i = 0; i < nedges; i++) begin
            dev_clk = 1'b1;
            repeat (H) tick();
            bits[i] = ps2data_in;
            if (i == 10) dev_data = ack;
            dev_clk = 1'b0;
            repeat (H) tick();
        end
        dev_clk = 1'b1;
        dev_data = 1'b1;
    endtask

    task automatic check_bits(input string name, input logic [10:0] bits, input logic [7:0] b);
        logic [10:0] exp;
        exp = frame_model(b);
        for (int i = 0; i < 11; i++)
            chk($sformatf("%s_bit%0d", name, i), bits[i], exp[i]);
    endtask

    task automatic expect_end(input string name, input bit exp_err);
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done === 1'b1 || err === 1'b1) tx_valid = 1'b0;
        end
        chk({name, "_done_pulses"}, done_cnt - d0, exp_err ? 0 : 1);
        chk({name, "_err_pulses"}, err_cnt - e0, exp_err ? 1 : 0);
        chk({name, "_ready_after"}, tx_ready, 1);
        chk({name, "_lines_released"}, {ps2clk_oe, ps2data_oe}, 0);
    endtask

    initial begin
        logic [10:0] bits;
        logic [7:0]  b;
        logic        a;
        int          n;
        int          d0;
        int          e0;

        // Reset state
        repeat (3) tick();
        chk("rst_oe", {ps2clk_oe, ps2data_oe}, 0);
        chk("rst_done_err", {done, err}, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", tx_ready, 1);

        // Set-LEDs command, acked
        send(PS2_CMD_SET_LEDS, 1'b0);
        device(1'b0, 11, bits);
        check_bits("ed", bits, PS2_CMD_SET_LEDS);
        expect_end("ed", 1'b0);

        // Enable command, acked
        send(PS2_CMD_ENABLE, 1'b0);
        device(1'b0, 11, bits);
        check_bits("f4", bits, PS2_CMD_ENABLE);
        expect_end("f4", 1'b0);

        // Device never clocks: timeout measured from the first SEND cycle
        d0 = done_cnt;
        send(8'h55, 1'b0);
        n = 0;
        while (err !== 1'b1 && n < TO + 100) begin
            tick();
            n++;
        end
        chk("timeout_len", n, TO);
        chk("timeout_lines", {ps2clk_oe, ps2data_oe}, 0);
        chk("timeout_no_done", done, 0);
        tick();
        chk("timeout_ready_next", tx_ready, 1);
        chk("timeout_err_single", err, 0);
        chk("timeout_done_cnt", done_cnt - d0, 0);

        // Device answers with ack bit 1
        send(PS2_CMD_ENABLE, 1'b0);
        device(1'b1, 11, bits);
        check_bits("nack", bits, PS2_CMD_ENABLE);
        expect_end("nack", ACK_CHK);

        // Reset after the fourth edge aborts silently
        send(PS2_CMD_SET_LEDS, 1'b0);
        device(1'b0, 4, bits);
        d0 = done_cnt;
        e0 = err_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_lines", {ps2clk_oe, ps2data_oe}, 0);
        chk("midrst_ready", tx_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_no_err", err_cnt - e0, 0);
        send(PS2_CMD_RESET, 1'b0);
        device(1'b0, 11, bits);
        check_bits("ff", bits, PS2_CMD_RESET);
        expect_end("ff", 1'b0);

        // tx_valid held with a different byte during the frame is ignored
        send(8'h3C, 1'b1);
        device(1'b0, 11, bits);
        check_bits("hold", bits, 8'h3C);
        expect_end("hold", 1'b0);

        // Random bytes and ack values
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            a = 1'($urandom_range(1, 0));
            send(b, 1'b0);
            device(a, 11, bits);
            check_bits($sformatf("rnd%0d", k), bits, b);
            expect_end($sformatf("rnd%0d", k), ACK_CHK && a);
        end

        chk("never_done_and_err", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clk cycles ps2clk is held low before the request (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, maximum clk cycles from clock release to frame end (15 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tx_data  input  8  command byte to send to the device.
REQ-006 SHALL have port tx_valid  input  1  tx_data valid; accepted when tx_valid & tx_ready.
REQ-007 SHALL have port tx_ready  output  1  high only in IDLE.
REQ-008 SHALL have port ps2clk_in  input  1  raw PS/2 clock line level, asynchronous.
REQ-009 SHALL have port ps2data_in  input  1  raw PS/2 data line level, asynchronous.
REQ-010 SHALL have port ps2clk_oe  output  1  1 = drive clock line low, 0 = release (open-drain).
REQ-011 SHALL have port ps2data_oe  output  1  1 = drive data line low, 0 = release.
REQ-012 SHALL have port done  output  1  one-cycle pulse, frame completed successfully.
REQ-013 SHALL have port err  output  1  one-cycle pulse, frame aborted (timeout or bad ack).

Function
REQ-014 SHALL synchronize ps2clk_in/ps2data_in through 2 flops; falling edge = previous synced clk 1, current synced clk 0.
REQ-015 SHALL implement states IDLE, INHIBIT, SEND, ACK, WAIT_IDLE.
REQ-016 IDLE: lines released; on tx_valid & tx_ready latch tx_data, compute odd parity (~^tx_data), go INHIBIT next cycle.
REQ-017 INHIBIT: ps2clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2data_oe=1 in its last cycle; then SEND.
REQ-018 SEND: ps2clk_oe=0, ps2data_oe=1 (start bit 0) until first falling edge; on falling edges 1..10 present data bit0..bit7 (LSB first), parity, stop (released) respectively; ps2data_oe = ~bit.
REQ-019 ACK: entered after 10th edge with data released; on 11th falling edge sample synced data as ack bit (0 = acknowledged), go WAIT_IDLE.
REQ-020 WAIT_IDLE: when both synced lines are 1, pulse done (or err per REQ-027) and go IDLE.
REQ-021 Timeout counter SHALL start at entry to SEND; reaching TIMEOUT_CYCLES in SEND/ACK/WAIT_IDLE pulses err, releases both lines same cycle, returns to IDLE.
REQ-022 tx_valid while tx_ready=0 SHALL be ignored; no queuing.
REQ-023 done and err SHALL never assert in the same cycle; frame byte latched, tx_data changes mid-frame have no effect.

Reset
REQ-024 On rst_n low: state IDLE, ps2clk_oe=0, ps2data_oe=0, done=0, err=0, tx_ready=1 after release, counters and shift register 0.
REQ-025 Reset mid-frame SHALL release both lines asynchronously; no done/err pulse for the aborted frame.

Configuration
REQ-026 Macro PS2_TX_ACK_CHECK_EN SHALL select ack checking.
REQ-027 With PS2_TX_ACK_CHECK_EN: ack bit 1 at edge 11 -> err pulse instead of done at WAIT_IDLE exit.
REQ-028 Without PS2_TX_ACK_CHECK_EN: ack bit ignored, done always pulsed at WAIT_IDLE exit (timeout still gives err).

Structure
REQ-029 Package ps2_pkg SHALL hold the state enum typedef, frame length constant (11 edges) and PS/2 command constants (0xED set-LEDs, 0xF4 enable, 0xFF reset).
REQ-030 Sub-module ps2_sync SHALL contain 2-flop synchronizers and falling-edge detector, reusable by the receiver.

Verification
REQ-031 Send 0xED, device model clocks 11 edges, acks 0 -> bits on data line 0,1,0,1,1,0,1,1,1,1(parity),1(stop); done pulse once.
REQ-032 Send 0xF4 -> data bits 0,0,1,0,1,1,1,1, parity 0, stop 1; ps2clk_oe high exactly INHIBIT_CYCLES cycles before.
REQ-033 Device never clocks -> err pulse TIMEOUT_CYCLES after SEND entry, both oe 0, tx_ready 1 next cycle.
REQ-034 Ack bit 1 at edge 11 -> err with PS2_TX_ACK_CHECK_EN, done without it.
REQ-035 rst_n low after edge 4 of 0xED -> both oe 0 immediately, no done/err; next 0xFF frame completes with done.
REQ-036 tx_valid held during frame with tx_data 0xAA -> ignored; only first byte transmitted.
